// File: rtl/io_pattern_sequencer_pkg.sv
// Shared definitions for the GPIO pattern sequencer: register offsets, control/status
// bit positions, sequencer state encoding and the idle pad reset value.
package io_seq_pkg;

   localparam logic [7:0] OFF_CTRL   = 8'h00;
   localparam logic [7:0] OFF_STATUS = 8'h04;
   localparam logic [7:0] OFF_PERIOD = 8'h08;
   localparam logic [7:0] OFF_LENGTH = 8'h0C;
   localparam logic [7:0] OFF_STATIC = 8'h10;

   localparam int CTRL_START  = 0;
   localparam int CTRL_STOP   = 1;
   localparam int CTRL_LOOP   = 2;
   localparam int CTRL_IRQ_EN = 3;
   localparam int STATUS_DONE = 2;
   localparam int STATUS_IDX  = 8;

   // {oeb, out}: all pads tristated, outputs low
   localparam logic [7:0] STATIC_RST = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

endpackage

// File: rtl/io_pattern_sequencer_if.sv
// Wishbone slave bundle between the wrapper and the pattern sequencer.
interface io_pattern_sequencer_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/io_pattern_sequencer_wb_regs.sv
// Wishbone decode, single-cycle ack, CSR storage and pattern table for the sequencer.
module io_seq_wb_regs
   import io_seq_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          DEPTH     = 16,
   parameter int          PRESC_W   = 16,
   parameter int          IDXW      = $clog2(DEPTH)
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   io_pattern_sequencer_if.slave wbs,
   input  seq_state_e          state_i,
   input  logic [IDXW-1:0]     index_i,
   input  logic                done_set_i,
   input  logic [IDXW-1:0]     fetch_idx_i,
   output logic [PRESC_W-1:0]  period_o,
   output logic [IDXW-1:0]     length_o,
   output logic [7:0]          static_o,
   output logic                loop_o,
   output logic                irq_en_o,
   output logic                done_o,
   output logic                start_o,
   output logic                stop_o,
   output logic [7:0]          pat_o
);

   logic                ack_q;
   logic [31:0]         dat_q;
   logic [PRESC_W-1:0]  period_q;
   logic [IDXW-1:0]     length_q;
   logic [7:0]          static_q;
   logic                loop_q;
   logic                irq_en_q;
   logic                done_q;
   logic [7:0]          pat_q [DEPTH];

   logic        hit, acc, wr, pat_hit;
   logic [7:0]  off;
   logic [5:0]  pidx;
   logic [31:0] rdata;

   assign off     = wbs.wbs_adr_i[7:0];
   assign hit     = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign acc     = wbs.wbs_stb_i & wbs.wbs_cyc_i & hit & ~ack_q;
   assign wr      = acc & wbs.wbs_we_i & wbs.wbs_sel_i[0];
   assign pidx    = {1'b0, off[6:2]};
   assign pat_hit = off[7] & (off[1:0] == 2'b00) & ({1'b0, pidx} < 7'(DEPTH));

   assign start_o = wr & (off == OFF_CTRL) & wbs.wbs_dat_i[CTRL_START];
   assign stop_o  = wr & (off == OFF_CTRL) & wbs.wbs_dat_i[CTRL_STOP];

   always_comb begin
      rdata = '0;
      case (off)
         OFF_CTRL: begin
            rdata[CTRL_LOOP]   = loop_q;
            rdata[CTRL_IRQ_EN] = irq_en_q;
         end
         OFF_STATUS: begin
            rdata[1:0]                = state_i;
            rdata[STATUS_DONE]        = done_q;
            rdata[STATUS_IDX +: IDXW] = index_i;
         end
         OFF_PERIOD: rdata[PRESC_W-1:0] = period_q;
         OFF_LENGTH: rdata[IDXW-1:0]    = length_q;
         OFF_STATIC: rdata[7:0]         = static_q;
         default:    if (pat_hit) rdata[7:0] = pat_q[pidx[IDXW-1:0]];
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         ack_q    <= 1'b0;
         dat_q    <= '0;
         period_q <= '0;
         length_q <= '0;
         static_q <= STATIC_RST;
         loop_q   <= 1'b0;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) pat_q[i] <= '0;
      end else begin
         ack_q <= acc;
         dat_q <= acc ? rdata : '0;
         if (wr) begin
            case (off)
               OFF_CTRL: begin
                  loop_q   <= wbs.wbs_dat_i[CTRL_LOOP];
                  irq_en_q <= wbs.wbs_dat_i[CTRL_IRQ_EN];
               end
               OFF_PERIOD: period_q <= wbs.wbs_dat_i[PRESC_W-1:0];
               OFF_LENGTH: length_q <= wbs.wbs_dat_i[IDXW-1:0];
               OFF_STATIC: static_q <= wbs.wbs_dat_i[7:0];
               default:    if (pat_hit) pat_q[pidx[IDXW-1:0]] <= wbs.wbs_dat_i[7:0];
            endcase
         end
         // a completion landing on the same edge as the W1C keeps done set
         if (done_set_i)
            done_q <= 1'b1;
         else if (wr && off == OFF_STATUS && wbs.wbs_dat_i[STATUS_DONE])
            done_q <= 1'b0;
      end
   end

   assign wbs.wbs_ack_o = ack_q;
   assign wbs.wbs_dat_o = dat_q;
   assign period_o      = period_q;
   assign length_o      = length_q;
   assign static_o      = static_q;
   assign loop_o        = loop_q;
   assign irq_en_o      = irq_en_q;
   assign done_o        = done_q;
   assign pat_o         = pat_q[fetch_idx_i];

endmodule

// File: rtl/io_pattern_sequencer.sv
// GPIO pattern sequencer for pads io[11:8]: static value when idle, otherwise steps a
// programmable {oeb,out} table with a per-step hold period; raises irq at sequence end.
//
//   state | meaning
//   IDLE  | pads driven from STATIC
//   RUN   | pads driven from PATTERN[index], period counter running
//   DONE  | one-shot finished, pads hold PATTERN[LENGTH]
module io_pattern_sequencer
   import io_seq_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          DEPTH     = 16,
   parameter int          PRESC_W   = 16
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_n_i,
   io_pattern_sequencer_if.slave wbs,
   output logic [3:0]            pad_out_o,
   output logic [3:0]            pad_oeb_o,
   output logic                  irq_o
);

   localparam int IDXW = $clog2(DEPTH);

   seq_state_e          state_q, state_d;
   logic [IDXW-1:0]     index_q, index_d;
   logic [PRESC_W-1:0]  cnt_q, cnt_d;
   logic [7:0]          pad_q, pad_d;
   logic                irq_q;

   logic [PRESC_W-1:0]  period;
   logic [IDXW-1:0]     length, fetch_idx;
   logic [7:0]          static_val, pat;
   logic                loop_en, irq_en, done, start, stop, done_set;

   assign fetch_idx = (state_q == ST_DONE) ? length : index_q;

   io_seq_wb_regs #(
      .BASE_ADDR (BASE_ADDR),
      .DEPTH     (DEPTH),
      .PRESC_W   (PRESC_W),
      .IDXW      (IDXW)
   ) u_regs (
      .clk_i       (wb_clk_i),
      .rst_n_i     (wb_rst_n_i),
      .wbs         (wbs),
      .state_i     (state_q),
      .index_i     (index_q),
      .done_set_i  (done_set),
      .fetch_idx_i (fetch_idx),
      .period_o    (period),
      .length_o    (length),
      .static_o    (static_val),
      .loop_o      (loop_en),
      .irq_en_o    (irq_en),
      .done_o      (done),
      .start_o     (start),
      .stop_o      (stop),
      .pat_o       (pat)
   );

   always_comb begin
      state_d  = state_q;
      index_d  = index_q;
      cnt_d    = cnt_q;
      done_set = 1'b0;
      if (state_q == ST_RUN) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
         end else if (index_q < length) begin
            index_d = index_q + 1'b1;
            cnt_d   = period;
         end else if (loop_en) begin
            index_d = '0;
            cnt_d   = period;
         end else begin
            state_d  = ST_DONE;
            done_set = 1'b1;
         end
      end
      if (start) begin
         state_d  = ST_RUN;
         index_d  = '0;
         cnt_d    = period;
         done_set = 1'b0;
      end
      // stop overrides a simultaneous start
      if (stop) begin
         state_d  = ST_IDLE;
         done_set = 1'b0;
      end
      pad_d = (state_q == ST_IDLE) ? static_val : pat;
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state_q <= ST_IDLE;
         index_q <= '0;
         cnt_q   <= '0;
         pad_q   <= STATIC_RST;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         cnt_q   <= cnt_d;
         pad_q   <= pad_d;
         irq_q   <= done & irq_en;
      end
   end

   assign pad_out_o = pad_q[3:0];
   assign pad_oeb_o = pad_q[7:4];
   assign irq_o     = irq_q;

endmodule

// File: tb/tb_io_pattern_sequencer.sv
// Randomized bench for io_pattern_sequencer against a step-count model of the pad trace.
module tb_io_pattern_sequencer;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam logic [31:0] A_CTRL = BASE + 32'h00;
   localparam logic [31:0] A_STATUS = BASE + 32'h04;
   localparam logic [31:0] A_PERIOD = BASE + 32'h08;
   localparam logic [31:0] A_LENGTH = BASE + 32'h0C;
   localparam logic [31:0] A_STATIC = BASE + 32'h10;
   localparam logic [31:0] A_PAT = BASE + 32'h80;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [3:0] pad_out, pad_oeb;
   logic irq;

   int errors = 0;
   int checks = 0;
   logic [7:0] tbl [16];
   logic [7:0] static_v = 8'hF0;

   io_pattern_sequencer_if wb();

   io_pattern_sequencer #(
      .BASE_ADDR (BASE),
      .DEPTH     (16),
      .PRESC_W   (16)
   ) dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .wbs        (wb),
      .pad_out_o  (pad_out),
      .pad_oeb_o  (pad_oeb),
      .irq_o      (irq)
   );

   always #5 clk = ~clk;

   // expected {oeb,out} after n cycles of a run: each entry lasts p+1 cycles
   function automatic logic [7:0] exp_pad(int n, int p, int l, bit lp);
      int step;
      step = n / (p + 1);
      if (lp) step = step % (l + 1);
      else if (step > l) step = l;
      return tbl[step];
   endfunction

   task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                            output logic [31:0] rdat, output bit acked);
      @(negedge clk);
      wb.wbs_adr_i = adr;
      wb.wbs_dat_i = wdat;
      wb.wbs_we_i  = we;
      wb.wbs_sel_i = 4'hF;
      wb.wbs_stb_i = 1'b1;
      wb.wbs_cyc_i = 1'b1;
      acked = 1'b0;
      rdat  = '0;
      for (int i = 0; i < 8 && !acked; i++) begin
         @(posedge clk);
         #1;
         if (wb.wbs_ack_o) begin
            acked = 1'b1;
            rdat  = wb.wbs_dat_o;
         end
      end
      wb.wbs_stb_i = 1'b0;
      wb.wbs_cyc_i = 1'b0;
      wb.wbs_we_i  = 1'b0;
   endtask

   task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
      logic [31:0] r;
      bit a;
      wb_access(adr, 1'b1, dat, r, a);
      checks++;
      if (!a) begin
         errors++;
         $display("FAIL write_ack adr=%h got no ack, required ack", adr);
      end
   endtask

   task automatic rd(input logic [31:0] adr, output logic [31:0] dat);
      bit a;
      wb_access(adr, 1'b0, 32'h0, dat, a);
      checks++;
      if (!a) begin
         errors++;
         $display("FAIL read_ack adr=%h got no ack, required ack", adr);
      end
   endtask

   task automatic load_table(input int l);
      for (int i = 0; i <= l; i++) wr(A_PAT + 32'(4 * i), {24'h0, tbl[i]});
   endtask

   // follow the pads for ncyc cycles after a start ack edge
   task automatic trace(input string name, input int p, input int l, input bit lp,
                        input bit ien, input int ncyc);
      int t;
      t = (l + 1) * (p + 1);
      for (int n = 0; n < ncyc; n++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({pad_oeb, pad_out} !== exp_pad(n, p, l, lp)) begin
            errors++;
            $display("FAIL %s pads n=%0d got %h required %h", name, n, {pad_oeb, pad_out},
                     exp_pad(n, p, l, lp));
         end
         if (!lp) begin
            checks++;
            if (irq !== (ien && n >= t)) begin
               errors++;
               $display("FAIL %s irq n=%0d got %b required %b", name, n, irq, ien && n >= t);
            end
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] r;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      checks++;
      if ({pad_oeb, pad_out, irq, wb.wbs_ack_o} !== {4'hF, 4'h0, 1'b0, 1'b0} || wb.wbs_dat_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs got oeb=%h out=%h irq=%b ack=%b dat=%h required F 0 0 0 0",
                  pad_oeb, pad_out, irq, wb.wbs_ack_o, wb.wbs_dat_o);
      end
      rd(A_STATUS, r);
      checks++;
      if (r !== 32'h0) begin
         errors++;
         $display("FAIL reset_status got %h required 0", r);
      end
      rd(A_STATIC, r);
      checks++;
      if (r !== 32'hF0) begin
         errors++;
         $display("FAIL reset_static got %h required f0", r);
      end
   endtask

   task automatic test_static();
      logic [31:0] r;
      logic [7:0] v;
      for (int k = 0; k < 3; k++) begin
         v = (k == 0) ? 8'hA5 : 8'($urandom);
         wr(A_STATIC, {24'h0, v});
         static_v = v;
         @(posedge clk);
         #1;
         checks++;
         if ({pad_oeb, pad_out} !== v) begin
            errors++;
            $display("FAIL static_pads got %h required %h", {pad_oeb, pad_out}, v);
         end
         rd(A_STATIC, r);
         checks++;
         if (r !== {24'h0, v}) begin
            errors++;
            $display("FAIL static_readback got %h required %h", r, v);
         end
      end
   endtask

   task automatic test_one_shot();
      logic [31:0] r;
      int p, l;
      bit ien;
      tbl[0] = 8'h01; tbl[1] = 8'h02; tbl[2] = 8'h04;
      load_table(2);
      wr(A_PERIOD, 32'd2);
      wr(A_LENGTH, 32'd2);
      wr(A_CTRL, 32'h9);
      trace("one_shot", 2, 2, 1'b0, 1'b1, 12);
      rd(A_STATUS, r);
      checks++;
      if (r !== 32'h206) begin
         errors++;
         $display("FAIL one_shot_status got %h required 206", r);
      end
      wr(A_STATUS, 32'h4);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL w1c_irq got %b required 0", irq);
      end
      rd(A_STATUS, r);
      checks++;
      if (r !== 32'h202) begin
         errors++;
         $display("FAIL w1c_status got %h required 202", r);
      end
      for (int k = 0; k < 3; k++) begin
         p = int'($urandom_range(0, 3));
         l = int'($urandom_range(0, 7));
         ien = 1'($urandom);
         for (int i = 0; i <= l; i++) tbl[i] = 8'($urandom);
         load_table(l);
         wr(A_PERIOD, 32'(p));
         wr(A_LENGTH, 32'(l));
         wr(A_CTRL, {28'h0, ien, 3'b001});
         trace("rand_one_shot", p, l, 1'b0, ien, (l + 1) * (p + 1) + 3);
         wr(A_STATUS, 32'h4);
         repeat (2) @(posedge clk);
      end
   endtask

   task automatic test_loop_stop();
      logic [31:0] r;
      tbl[0] = 8'h01; tbl[1] = 8'h02; tbl[2] = 8'h04;
      load_table(2);
      wr(A_PERIOD, 32'd0);
      wr(A_LENGTH, 32'd2);
      wr(A_CTRL, 32'h5);
      trace("loop", 0, 2, 1'b1, 1'b0, 10);
      wr(A_CTRL, 32'h2);
      @(posedge clk);
      #1;
      checks++;
      if ({pad_oeb, pad_out} !== static_v) begin
         errors++;
         $display("FAIL stop_pads got %h required %h", {pad_oeb, pad_out}, static_v);
      end
      rd(A_STATUS, r);
      checks++;
      if (r[1:0] !== 2'd0) begin
         errors++;
         $display("FAIL stop_state got %0d required 0", r[1:0]);
      end
   endtask

   task automatic test_restart();
      logic [31:0] r;
      bit a;
      for (int i = 0; i <= 4; i++) tbl[i] = 8'($urandom);
      load_table(4);
      wr(A_PERIOD, 32'd1);
      wr(A_LENGTH, 32'd4);
      wr(A_CTRL, 32'h1);
      trace("pre_restart", 1, 4, 1'b0, 1'b0, 4);
      wr(A_CTRL, 32'h1);
      trace("restart", 1, 4, 1'b0, 1'b0, 6);
      wr(A_CTRL, 32'h3);
      @(posedge clk);
      #1;
      checks++;
      if ({pad_oeb, pad_out} !== static_v) begin
         errors++;
         $display("FAIL start_stop_pads got %h required %h", {pad_oeb, pad_out}, static_v);
      end
      rd(A_STATUS, r);
      checks++;
      if (r[1:0] !== 2'd0) begin
         errors++;
         $display("FAIL start_stop_state got %0d required 0", r[1:0]);
      end
      wb_access(BASE + 32'h110, 1'b1, 32'h33, r, a);
      checks++;
      if (a) begin
         errors++;
         $display("FAIL miss_ack got ack required none");
      end
      rd(A_STATIC, r);
      checks++;
      if (r !== {24'h0, static_v}) begin
         errors++;
         $display("FAIL miss_no_write got %h required %h", r, static_v);
      end
      rd(BASE + 32'h14, r);
      checks++;
      if (r !== 32'h0) begin
         errors++;
         $display("FAIL unmapped_read got %h required 0", r);
      end
   endtask

   task automatic test_midrun_reset();
      logic [31:0] r;
      for (int i = 0; i <= 3; i++) tbl[i] = 8'($urandom);
      load_table(3);
      wr(A_PERIOD, 32'd2);
      wr(A_LENGTH, 32'd3);
      wr(A_CTRL, 32'hD);
      trace("pre_reset", 2, 3, 1'b1, 1'b1, 3);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({pad_oeb, pad_out, irq, wb.wbs_ack_o} !== {4'hF, 4'h0, 1'b0, 1'b0} || wb.wbs_dat_o !== 32'h0) begin
         errors++;
         $display("FAIL midrun_reset got oeb=%h out=%h irq=%b ack=%b dat=%h required F 0 0 0 0",
                  pad_oeb, pad_out, irq, wb.wbs_ack_o, wb.wbs_dat_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      static_v = 8'hF0;
      rd(A_STATIC, r);
      checks++;
      if (r !== 32'hF0) begin
         errors++;
         $display("FAIL midrun_static got %h required f0", r);
      end
      rd(A_STATUS, r);
      checks++;
      if (r !== 32'h0) begin
         errors++;
         $display("FAIL midrun_status got %h required 0", r);
      end
   endtask

   initial begin
      wb.wbs_stb_i = 1'b0;
      wb.wbs_cyc_i = 1'b0;
      wb.wbs_we_i  = 1'b0;
      wb.wbs_sel_i = 4'h0;
      wb.wbs_dat_i = 32'h0;
      wb.wbs_adr_i = 32'h0;
      for (int i = 0; i < 16; i++) tbl[i] = 8'h00;
      test_reset();
      test_static();
      test_one_shot();
      test_loop_stop();
      test_restart();
      test_midrun_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
